pulse_stretcher: RTL and testbench
==================================

Name: pulse_stretcher

Overview:
- Other direction of the push-button path. The debouncer turns a noisy human input into clean single-clk pulses; this block turns clean single-clk pulses back into human-visible LED flashes.
- Each input pulse is queued as a count and replayed as one LED flash: a fixed ON time followed by a fixed dark GAP.
- Typical use: board LED status feedback driven directly by debounced button pulses or other internal event strobes.

Parameters:
- TICK_MAX, 1000000, prescaler period in clk cycles (10 ms at 100 MHz); must be >= 2.
- ON_TICKS, 20, LED-on duration in prescaler ticks; must be >= 1.
- GAP_TICKS, 10, LED-off gap between consecutive flashes in ticks; must be >= 1.
- QUEUE_W, 4, width of pending-flash counter; maximum queue depth = 2^QUEUE_W - 1.

Ports:
- clk, input, 1, system clock (100 MHz on-board oscillator).
- rst, input, 1, asynchronous, active-high reset.
- pulse, input, 1, single-clk event strobe, synchronous to clk.
- clr, input, 1, synchronous clear of the queue and of overflow.
- led, output, 1, stretched flash output, registered.
- busy, output, 1, high while state is ON or GAP.
- pending, output, QUEUE_W, number of queued flashes not yet started.
- overflow, output, 1, sticky: a pulse was dropped because the queue was full.

Behaviour:
- Reset, asynchronous with immediate effect:
  - state = IDLE.
  - led, busy, overflow = 0.
  - pending = 0.
  - prescaler and duration counters = 0.
- Prescaler:
  - Counts 0..TICK_MAX-1; tick = 1 for one clk when count == TICK_MAX-1.
  - Restarts at 0 on every state entry, so ON lasts exactly ON_TICKS*TICK_MAX clk and GAP exactly GAP_TICKS*TICK_MAX clk.
- Queue update, per edge, in priority order:
  1. clr: pending <= 0, overflow <= 0. Any pulse in the same cycle is discarded.
  2. pulse and decrement in the same cycle: pending unchanged, no overflow.
  3. pulse only: if pending == 2^QUEUE_W-1, hold the value and set overflow; else increment.
  4. decrement only: pending - 1.
- FSM:
  - IDLE: if pending != 0, go to ON on the next edge, decrement pending, led <= 1.
  - ON: after ON_TICKS ticks, go to GAP, led <= 0.
  - GAP: after GAP_TICKS ticks:
    - if pending != 0, go directly to ON, decrement, led <= 1;
    - else go to IDLE.
- Latency: pulse sampled at edge k gives pending = 1 after edge k. With the FSM in IDLE, led = 1 after edge k+1; pending returns to 0 at the same edge.
- busy is registered with the state: 1 in ON/GAP, 0 in IDLE.
- clr never aborts a flash in progress. The current ON/GAP completes, then the FSM returns to IDLE.
- A pulse arriving during ON/GAP is only queued. It never extends or restarts the current flash.
- No arithmetic wrap: pending saturates at the top and is only decremented when != 0.

Test Plan:
All scenarios use TICK_MAX=4, ON_TICKS=3, GAP_TICKS=2, QUEUE_W=2, giving ON = 12 clk, GAP = 8 clk, max pending = 3.
1. Single pulse at edge k:
   - pending = 1 after edge k, 0 after edge k+1.
   - led high exactly from edge k+1 to edge k+13.
   - busy high from edge k+1 to edge k+21, then 0.
2. Pulses at edges k, k+1, k+2:
   - pending reads 1, 1, 2.
   - Three 12-clk flashes start at edges k+1, k+21, k+41; busy falls at edge k+61.
3. Five consecutive pulses from IDLE:
   - First pulse starts a flash; pending saturates at 3.
   - Fifth pulse sets overflow = 1 and is dropped.
   - Exactly 4 flashes; overflow stays 1 afterwards.
4. pending = 3 and pulse coincident with the GAP->ON transition:
   - pending stays 3, overflow stays 0.
5. clr during ON with pending = 2 and overflow = 1:
   - pending = 0 and overflow = 0 next edge.
   - Current flash still lasts the full 12 clk, then 8 clk GAP, then IDLE; no further flashes.
6. rst asserted mid-ON, between clk edges:
   - led, busy, overflow = 0 and pending = 0 immediately.
   - After release, a new pulse gives the full 12-clk flash with the scenario-1 timing.

Source files
------------

// File: rtl/pulse_stretcher.sv
// Replays queued single-clk event strobes as LED flashes: ON_TICKS ticks lit,
// then GAP_TICKS ticks dark. The prescaler restarts on every state entry.
//
// state | meaning
// IDLE  | no flash in progress, waiting for a queued pulse
// ON    | led lit for ON_TICKS prescaler ticks
// GAP   | led dark for GAP_TICKS ticks before the next flash may start
module pulse_stretcher #(
  parameter int TICK_MAX  = 1000000,
  parameter int ON_TICKS  = 20,
  parameter int GAP_TICKS = 10,
  parameter int QUEUE_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pulse,
  input  logic               clr,
  output logic               led,
  output logic               busy,
  output logic [QUEUE_W-1:0] pending,
  output logic               overflow
);

  localparam int PW    = $clog2(TICK_MAX);
  localparam int MAXT  = (ON_TICKS > GAP_TICKS) ? ON_TICKS : GAP_TICKS;
  localparam int DW    = $clog2(MAXT + 1);
  localparam logic [QUEUE_W-1:0] Q_FULL = '1;

  typedef enum logic [1:0] {IDLE, ON, GAP} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [DW-1:0]   dur_q, dur_d;
  logic            led_d, busy_d;
  logic            tick, done, start;

  assign tick = (presc_q == PW'(TICK_MAX - 1));
  // dur_q counts remaining ticks down; the phase ends on the tick seen at zero
  assign done = tick && (dur_q == '0);

  always_comb begin
    state_d = state_q;
    led_d   = led;
    busy_d  = busy;
    dur_d   = dur_q;
    presc_d = tick ? '0 : presc_q + PW'(1);
    start   = 1'b0;
    case (state_q)
      IDLE: begin
        presc_d = '0;
        if (pending != '0) begin
          state_d = ON;
          start   = 1'b1;
          led_d   = 1'b1;
          busy_d  = 1'b1;
          dur_d   = DW'(ON_TICKS - 1);
        end
      end
      ON: begin
        if (done) begin
          state_d = GAP;
          led_d   = 1'b0;
          dur_d   = DW'(GAP_TICKS - 1);
          presc_d = '0;
        end else if (tick) begin
          dur_d = dur_q - DW'(1);
        end
      end
      GAP: begin
        if (done) begin
          presc_d = '0;
          if (pending != '0) begin
            state_d = ON;
            start   = 1'b1;
            led_d   = 1'b1;
            dur_d   = DW'(ON_TICKS - 1);
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
            dur_d   = '0;
          end
        end else if (tick) begin
          dur_d = dur_q - DW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        led_d   = 1'b0;
        busy_d  = 1'b0;
        dur_d   = '0;
        presc_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      presc_q <= '0;
      dur_q   <= '0;
      led     <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      dur_q   <= dur_d;
      led     <= led_d;
      busy    <= busy_d;
    end
  end

  // clr wins over everything; a pulse coinciding with a flash start nets to zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending  <= '0;
      overflow <= 1'b0;
    end else if (clr) begin
      pending  <= '0;
      overflow <= 1'b0;
    end else if (pulse && start) begin
      pending <= pending;
    end else if (pulse) begin
      if (pending == Q_FULL) overflow <= 1'b1;
      else                   pending  <= pending + QUEUE_W'(1);
    end else if (start) begin
      pending <= pending - QUEUE_W'(1);
    end
  end

endmodule

// File: tb/tb_pulse_stretcher.sv
// Bench for pulse_stretcher: clock-count flash model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_pulse_stretcher;

  localparam int TICK_MAX  = 4;
  localparam int ON_TICKS  = 3;
  localparam int GAP_TICKS = 2;
  localparam int QUEUE_W   = 2;
  localparam int ON_CLK    = ON_TICKS * TICK_MAX;
  localparam int CYC_CLK   = (ON_TICKS + GAP_TICKS) * TICK_MAX;
  localparam int QMAX      = (1 << QUEUE_W) - 1;

  logic               clk, rst, pulse, clr;
  logic               led, busy, overflow;
  logic [QUEUE_W-1:0] pending;

  int n_pass = 0;
  int n_tot  = 0;

  pulse_stretcher #(
    .TICK_MAX(TICK_MAX), .ON_TICKS(ON_TICKS), .GAP_TICKS(GAP_TICKS), .QUEUE_W(QUEUE_W)
  ) dut (
    .clk(clk), .rst(rst), .pulse(pulse), .clr(clr),
    .led(led), .busy(busy), .pending(pending), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
  endtask

  // Model: a flash is a window of CYC_CLK clocks, lit for the first ON_CLK of them
  int m_pend;
  int m_t;
  bit m_ov, m_act;

  always @(posedge clk or posedge rst) begin : model
    bit st;
    if (rst) begin
      m_pend = 0; m_ov = 0; m_act = 0; m_t = 0;
    end else begin
      st = 0;
      if (m_act) begin
        if (m_t == CYC_CLK - 1) begin
          if (m_pend != 0) st = 1;
          else m_act = 0;
        end else m_t++;
      end else if (m_pend != 0) st = 1;
      if (st) begin m_act = 1; m_t = 0; end
      if (clr) begin m_pend = 0; m_ov = 0; end
      else if (pulse && st) ;
      else if (pulse) begin
        if (m_pend == QMAX) m_ov = 1;
        else m_pend++;
      end else if (st) m_pend--;
    end
  end

  always @(negedge clk) begin
    chk("model_led", led, int'(m_act && m_t < ON_CLK));
    chk("model_busy", busy, int'(m_act));
    chk("model_pending", pending, m_pend);
    chk("model_overflow", overflow, int'(m_ov));
  end

  task automatic scen1();
    pulse = 1; @(negedge clk); pulse = 0;
    chk("s1_pend_k", pending, 1); chk("s1_led_k", led, 0);
    @(negedge clk);
    chk("s1_pend_k1", pending, 0); chk("s1_led_k1", led, 1); chk("s1_busy_k1", busy, 1);
    repeat (11) @(negedge clk);
    chk("s1_led_k12", led, 1);
    @(negedge clk);
    chk("s1_led_k13", led, 0); chk("s1_busy_k13", busy, 1);
    repeat (7) @(negedge clk);
    chk("s1_busy_k20", busy, 1);
    @(negedge clk);
    chk("s1_busy_k21", busy, 0);
  endtask

  initial begin
    int rises;
    logic prev;
    rst = 1; pulse = 0; clr = 0;
    repeat (2) @(negedge clk);
    chk("rst_led", led, 0); chk("rst_busy", busy, 0);
    chk("rst_pend", pending, 0); chk("rst_ovf", overflow, 0);
    rst = 0;
    repeat (2) @(negedge clk);

    scen1();
    repeat (3) @(negedge clk);

    // three back-to-back pulses
    pulse = 1; @(negedge clk); chk("s2_pend_k", pending, 1);
    @(negedge clk); chk("s2_pend_k1", pending, 1);
    @(negedge clk); chk("s2_pend_k2", pending, 2);
    pulse = 0;
    repeat (18) @(negedge clk); chk("s2_led_k20", led, 0);
    @(negedge clk); chk("s2_led_k21", led, 1);
    repeat (20) @(negedge clk); chk("s2_led_k41", led, 1);
    repeat (19) @(negedge clk); chk("s2_busy_k60", busy, 1);
    @(negedge clk); chk("s2_busy_k61", busy, 0);
    repeat (2) @(negedge clk);

    // five pulses: saturation and overflow
    pulse = 1;
    @(negedge clk); chk("s3_pend_k", pending, 1);
    @(negedge clk); chk("s3_pend_k1", pending, 1);
    @(negedge clk); chk("s3_pend_k2", pending, 2);
    @(negedge clk); chk("s3_pend_k3", pending, 3); chk("s3_ovf_k3", overflow, 0);
    @(negedge clk); chk("s3_pend_k4", pending, 3); chk("s3_ovf_k4", overflow, 1);
    pulse = 0;
    rises = 1; prev = led;
    repeat (81) begin
      @(negedge clk);
      if (led && !prev) rises++;
      prev = led;
    end
    chk("s3_flashes", rises, 4); chk("s3_busy_end", busy, 0); chk("s3_ovf_end", overflow, 1);

    // full queue plus pulse at the GAP->ON handoff
    clr = 1; @(negedge clk); clr = 0;
    chk("clr_pend", pending, 0); chk("clr_ovf", overflow, 0);
    pulse = 1; repeat (4) @(negedge clk); pulse = 0;
    chk("s4_pend_k3", pending, 3);
    repeat (17) @(negedge clk);
    chk("s4_led_k20", led, 0); chk("s4_busy_k20", busy, 1);
    pulse = 1; @(negedge clk); pulse = 0;
    chk("s4_pend_k21", pending, 3); chk("s4_ovf_k21", overflow, 0); chk("s4_led_k21", led, 1);

    // clr during ON leaves the flash intact
    pulse = 1; @(negedge clk); pulse = 0;
    chk("s5_ovf_set", overflow, 1);
    repeat (19) @(negedge clk);
    chk("s5_pend_k41", pending, 2); chk("s5_led_k41", led, 1);
    clr = 1; @(negedge clk); clr = 0;
    chk("s5_pend_clr", pending, 0); chk("s5_ovf_clr", overflow, 0); chk("s5_led_clr", led, 1);
    repeat (10) @(negedge clk); chk("s5_led_k52", led, 1);
    @(negedge clk); chk("s5_led_k53", led, 0); chk("s5_busy_k53", busy, 1);
    repeat (7) @(negedge clk); chk("s5_busy_k60", busy, 1);
    @(negedge clk); chk("s5_busy_k61", busy, 0);
    repeat (30) @(negedge clk);
    chk("s5_idle_led", led, 0); chk("s5_idle_busy", busy, 0);

    // async reset mid-ON
    pulse = 1; repeat (5) @(negedge clk); pulse = 0;
    repeat (3) @(negedge clk);
    chk("s6_pre_led", led, 1); chk("s6_pre_ovf", overflow, 1);
    #2 rst = 1;
    #1;
    chk("s6_led", led, 0); chk("s6_busy", busy, 0);
    chk("s6_pend", pending, 0); chk("s6_ovf", overflow, 0);
    @(negedge clk); #2 rst = 0;
    @(negedge clk);
    scen1();

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      pulse = ($urandom_range(0, 5) == 0);
      clr   = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 999) == 0) begin
        #2 rst = 1;
        @(negedge clk); #2 rst = 0;
      end
    end
    @(negedge clk);
    pulse = 0; clr = 0;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
